// File: rtl/fpu_pkg.sv
// Shared FPU definitions: NOP word, RISC-V FP major opcodes, funct5 codes
// and the queue entry layout.
package fpu_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OPC_OP_FP    = 7'b1010011;
    localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OPC_STORE_FP = 7'b0100111;

    typedef enum logic [4:0] {
        F5_FADD    = 5'b00000,
        F5_FSUB    = 5'b00001,
        F5_FMUL    = 5'b00010,
        F5_FDIV    = 5'b00011,
        F5_FSGNJ   = 5'b00100,
        F5_FMINMAX = 5'b00101,
        F5_FSQRT   = 5'b01011,
        F5_FCMP    = 5'b10100,
        F5_FCVT_W  = 5'b11000,
        F5_FCVT_S  = 5'b11010,
        F5_FMV_X   = 5'b11100,
        F5_FMV_W   = 5'b11110
    } funct5_e;

    // Instruction word in the upper half so a queue entry reads naturally in waveforms.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] intop;
    } entry_t;

    function automatic logic [31:0] make_op_fp(funct5_e f5, logic [4:0] rs2, logic [4:0] rs1,
                                               logic [2:0] rm, logic [4:0] rd);
        return {f5, 2'b00, rs2, rs1, rm, rd, OPC_OP_FP};
    endfunction

endpackage

// File: rtl/fpu_issue_queue_if.sv
// Decode-side and FPU-side signals of the FP issue queue; the queue uses the
// slave view, the decode/FPU environment the master view.
interface fpu_issue_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_inst;
    logic [31:0]   in_intop;
    logic          flush;
    logic          fpu_hazard;
    logic [31:0]   fpu_inst;
    logic          fpu_is_legl;
    logic [31:0]   fpu_intreg;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_inst, in_intop, flush, fpu_hazard,
        input  in_ready, fpu_inst, fpu_is_legl, fpu_intreg, count
    );

    modport slave (
        input  in_valid, in_inst, in_intop, flush, fpu_hazard,
        output in_ready, fpu_inst, fpu_is_legl, fpu_intreg, count
    );

endinterface

// File: rtl/fpu_issue_fifo.sv
// Circular buffer of instruction/operand pairs with occupancy count; flush
// drops everything by snapping the read pointer onto the write pointer.
module fpu_issue_fifo
    import fpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wr_data,
    output entry_t        rd_data,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // NOTE: storage has no reset; count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fpu_issue_queue.sv
// FP issue stage: buffers decoded FP instructions, issues the head unless the
// FPU reports a hazard, and delays the integer operand one cycle toward FPU stage 1.
module fpu_issue_queue
    import fpu_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = NOP_WORD
) (
    input logic              clk,
    input logic              rst,
    fpu_issue_queue_if.slave bus
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic          push;
    logic          pop;
    logic          head_valid;
    logic          ready;
    logic [CW-1:0] fifo_count;
    entry_t        head;
    entry_t        wr_entry;
    logic [31:0]   intreg;

    assign wr_entry   = '{inst: bus.in_inst, intop: bus.in_intop};
    assign head_valid = (fifo_count != '0);

    // No pass-through when full: a slot freed by this cycle's issue is usable next cycle.
    assign ready = (fifo_count < DEPTH_C);
    assign push  = bus.in_valid & ready & ~bus.flush;
    assign pop   = head_valid & ~bus.fpu_hazard & ~bus.flush;

    fpu_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (bus.flush),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (fifo_count)
    );

    // Operand lands one cycle after issue, alongside the instruction in FPU stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intreg <= '0;
        end else if (pop) begin
            intreg <= head.intop;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.fpu_inst    = head_valid ? head.inst : NOP;
    assign bus.fpu_is_legl = pop;
    assign bus.fpu_intreg  = intreg;
    assign bus.count       = fifo_count;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Self-checking bench for fpu_issue_queue: a reference queue scoreboard is
// updated from driven stimulus and compared against DUT outputs every cycle.
module tb_fpu_issue_queue;
    import fpu_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   seq;
    bit   mon_en;

    entry_t      sb_q[$];
    logic [31:0] model_intreg;
    logic [31:0] inst_a;
    logic        exp_legl;
    logic        exp_push;
    int          n;

    fpu_issue_queue_if #(.DEPTH(DEPTH)) bus ();

    fpu_issue_queue #(
        .DEPTH (DEPTH),
        .NOP   (NOP_WORD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change just after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid);
        bus.in_valid = valid;
        bus.in_inst  = make_op_fp(funct5_e'(F5_FMUL), 5'(seq), 5'(seq + 1), 3'b111, 5'(seq + 2));
        bus.in_intop = $urandom;
        seq++;
    endtask

    task automatic drain();
        bus.in_valid   = 1'b0;
        bus.fpu_hazard = 1'b0;
        bus.flush      = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Scoreboard: compare against the reference state, then advance it with this cycle's inputs.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            n        = sb_q.size();
            exp_legl = (n != 0) && !bus.fpu_hazard && !bus.flush;
            exp_push = bus.in_valid && (n < DEPTH) && !bus.flush;
            check("count",    32'(bus.count),   32'(n));
            check("in_ready", 32'(bus.in_ready), 32'(n < DEPTH));
            check("fpu_inst", bus.fpu_inst, (n != 0) ? sb_q[0].inst : NOP_WORD);
            check("is_legl",  32'(bus.fpu_is_legl), 32'(exp_legl));
            check("intreg",   bus.fpu_intreg, model_intreg);
            if (bus.flush) begin
                sb_q.delete();
            end else begin
                if (exp_legl) begin
                    model_intreg = sb_q[0].intop;
                    void'(sb_q.pop_front());
                end
                if (exp_push) sb_q.push_back('{inst: bus.in_inst, intop: bus.in_intop});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        seq            = 1;
        mon_en         = 1'b1;
        model_intreg   = '0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_inst    = '0;
        bus.in_intop   = '0;
        bus.flush      = 1'b0;
        bus.fpu_hazard = 1'b0;
        repeat (3) step();
        rst = 1'b0;

        // Idle after reset
        repeat (10) step();

        // Single instruction: issue next cycle, operand the cycle after
        bus.in_valid = 1'b1;
        bus.in_inst  = make_op_fp(F5_FMV_W, 5'd0, 5'd10, 3'b000, 5'd1);
        bus.in_intop = 32'h4049_0FDB;
        inst_a       = bus.in_inst;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t2_inst", bus.fpu_inst, inst_a);
        check("t2_legl", 32'(bus.fpu_is_legl), 32'd1);
        step();
        @(negedge clk);
        check("t2_intreg", bus.fpu_intreg, 32'h4049_0FDB);
        check("t2_count", 32'(bus.count), 32'd0);
        step();

        // Fill under hazard, then release
        bus.fpu_hazard = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1);
            if (i == 0) inst_a = bus.in_inst;
            step();
        end
        bus.in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("t3_count", 32'(bus.count), 32'd4);
        check("t3_ready", 32'(bus.in_ready), 32'd0);
        check("t3_inst", bus.fpu_inst, inst_a);
        check("t3_legl", 32'(bus.fpu_is_legl), 32'd0);
        step();
        bus.fpu_hazard = 1'b0;
        @(negedge clk);
        check("t3_legl_rel", 32'(bus.fpu_is_legl), 32'd1);
        check("t3_ready_full", 32'(bus.in_ready), 32'd0);
        step();
        @(negedge clk);
        check("t3_ready_after", 32'(bus.in_ready), 32'd1);
        check("t3_count_after", 32'(bus.count), 32'd3);
        drain();

        // Full with in_valid and pop in the same cycle
        bus.fpu_hazard = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1);
            step();
        end
        bus.fpu_hazard = 1'b0;
        drive(1'b1);
        @(negedge clk);
        check("t4_ready_full", 32'(bus.in_ready), 32'd0);
        step();
        @(negedge clk);
        check("t4_count_3", 32'(bus.count), 32'd3);
        check("t4_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t4_count_keep", 32'(bus.count), 32'd3);
        drain();

        // Flush with three entries and in_valid high, then wrap pointers
        bus.fpu_hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1);
            step();
        end
        drive(1'b1);
        bus.flush = 1'b1;
        @(negedge clk);
        check("t5_ready_flush", 32'(bus.in_ready), 32'd1);
        check("t5_legl_flush", 32'(bus.fpu_is_legl), 32'd0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t5_count", 32'(bus.count), 32'd0);
        check("t5_inst", bus.fpu_inst, NOP_WORD);
        check("t5_legl", 32'(bus.fpu_is_legl), 32'd0);
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            drive(1'b1);
            bus.fpu_hazard = (i % 3 == 1);
            step();
        end
        drain();

        // Asynchronous reset mid-stall with two entries
        bus.fpu_hazard = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        check("t6_inst", bus.fpu_inst, NOP_WORD);
        check("t6_legl", 32'(bus.fpu_is_legl), 32'd0);
        check("t6_ready", 32'(bus.in_ready), 32'd1);
        check("t6_count", 32'(bus.count), 32'd0);
        check("t6_intreg", bus.fpu_intreg, 32'd0);
        sb_q.delete();
        model_intreg   = '0;
        bus.fpu_hazard = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
